// File: rtl/nn_seq_pkg.sv
// nn_seq_pkg: state encoding and shared helpers for the layer sequencer.
package nn_seq_pkg;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_KICK = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        KICK = ST_KICK,
        WAIT = ST_WAIT,
        GAP  = ST_GAP,
        DONE = ST_DONE,
        ERR  = ST_ERR
    } state_t;

    // Idle layer select points one past the last real layer.
    function automatic int idle_lsel(input int n_layers);
        return n_layers;
    endfunction
endpackage

// File: rtl/nn_wait_timer.sv
// nn_wait_timer: saturating per-layer wait counter with watchdog compare.
module nn_wait_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && !(&cnt))
            cnt <= cnt + 1'b1;
    end

    // Fires on the TIMEOUT-th enabled cycle so the caller can still let ready win that cycle.
    assign expired = (TIMEOUT != 0) && en && (32'(cnt) + 32'd1 >= 32'(TIMEOUT));
endmodule

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: kicks each layer of a parallel neuron array, waits for
// full ready, loads inter-layer registers and finally enables argmax.
module nn_layer_sequencer
    import nn_seq_pkg::*;
#(
    parameter int N_NEURONS = 10,
    parameter int N_LAYERS  = 3,
    parameter int TIMEOUT   = 1023,
    parameter int LSEL_W    = $clog2(N_LAYERS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_circuit,
    input  logic                 abort,
    input  logic [N_NEURONS-1:0] neuron_ready,
    output logic                 ready_circuit,
    output logic                 busy,
    output logic                 rst_hidden_regs,
    output logic                 start_neurons,
    output logic [LSEL_W-1:0]    layer_sel,
    output logic [N_LAYERS-2:0]  ld_layer,
    output logic                 en_max,
    output logic                 done,
    output logic                 timeout_err
);
    localparam int LD_W = N_LAYERS - 1;

    state_t            state;
    logic [LSEL_W-1:0] lyr;
    logic              all_rdy;
    logic              last;
    logic              hit;
    logic              fin;

    assign all_rdy = &neuron_ready;
    assign last    = lyr == LSEL_W'(N_LAYERS - 1);
    // Abort suppresses every strobe in the cycle it is seen.
    assign fin     = state == WAIT && all_rdy && !abort;

    assign ready_circuit   = state == IDLE;
    assign busy            = state != IDLE;
    assign start_neurons   = state == KICK && !abort;
    assign rst_hidden_regs = start_neurons && lyr == '0;
    assign layer_sel       = ready_circuit ? LSEL_W'(idle_lsel(N_LAYERS)) : lyr;
    assign ld_layer        = (fin && !last) ? LD_W'(1) << lyr : '0;
    assign en_max          = fin && last;
    assign done            = state == DONE && !abort;

    nn_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == KICK),
        .en      (state == WAIT),
        .expired (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lyr         <= '0;
            timeout_err <= 1'b0;
        end else if (abort && state != IDLE) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start_circuit) begin
                    state       <= KICK;
                    lyr         <= '0;
                    timeout_err <= 1'b0;
                end
                KICK: state <= WAIT;
                WAIT: if (all_rdy) begin
                    state <= last ? DONE : GAP;
                end else if (hit) begin
                    state       <= ERR;
                    timeout_err <= 1'b1;
                end
                GAP: begin
                    lyr   <= lyr + 1'b1;
                    state <= KICK;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: directed checks on three sequencer configurations.
module tb_nn_layer_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut0: 10 neurons, 3 layers, long watchdog
    logic       s0_start = 0, s0_abort = 0;
    logic [9:0] rdy0 = '0;
    logic       r0_rc, r0_busy, r0_rh, r0_sn, r0_em, r0_done, r0_te;
    logic [1:0] r0_ls, r0_ld;
    // dut1: 10 neurons, 3 layers, TIMEOUT=8
    logic       s1_start = 0, s1_abort = 0;
    logic [9:0] rdy1 = '0;
    logic       r1_rc, r1_busy, r1_rh, r1_sn, r1_em, r1_done, r1_te;
    logic [1:0] r1_ls, r1_ld;
    // dut2: 4 neurons, 5 layers, watchdog off
    logic       s2_start = 0, s2_abort = 0;
    logic [3:0] rdy2 = '0;
    logic       r2_rc, r2_busy, r2_rh, r2_sn, r2_em, r2_done, r2_te;
    logic [2:0] r2_ls;
    logic [3:0] r2_ld;

    nn_layer_sequencer #(.N_NEURONS(10), .N_LAYERS(3), .TIMEOUT(1023)) u0 (
        .clk(clk), .rst(rst), .start_circuit(s0_start), .abort(s0_abort), .neuron_ready(rdy0),
        .ready_circuit(r0_rc), .busy(r0_busy), .rst_hidden_regs(r0_rh), .start_neurons(r0_sn),
        .layer_sel(r0_ls), .ld_layer(r0_ld), .en_max(r0_em), .done(r0_done), .timeout_err(r0_te));
    nn_layer_sequencer #(.N_NEURONS(10), .N_LAYERS(3), .TIMEOUT(8)) u1 (
        .clk(clk), .rst(rst), .start_circuit(s1_start), .abort(s1_abort), .neuron_ready(rdy1),
        .ready_circuit(r1_rc), .busy(r1_busy), .rst_hidden_regs(r1_rh), .start_neurons(r1_sn),
        .layer_sel(r1_ls), .ld_layer(r1_ld), .en_max(r1_em), .done(r1_done), .timeout_err(r1_te));
    nn_layer_sequencer #(.N_NEURONS(4), .N_LAYERS(5), .TIMEOUT(0)) u2 (
        .clk(clk), .rst(rst), .start_circuit(s2_start), .abort(s2_abort), .neuron_ready(rdy2),
        .ready_circuit(r2_rc), .busy(r2_busy), .rst_hidden_regs(r2_rh), .start_neurons(r2_sn),
        .layer_sel(r2_ls), .ld_layer(r2_ld), .en_max(r2_em), .done(r2_done), .timeout_err(r2_te));

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int age0 = 0, age1 = 0, age2 = 0;
    int dly0 = 1, dly1 = 1, dly2 = 1;
    logic late0 = 0, stuck1 = 0;
    int n_rh0, n_sn0, n_em0, n_done0, done_cyc0, ld1_cyc0, n_te0;
    logic [15:0] ls_seq0, ld_seq0;
    int n_em1, n_done1, done_cyc1, te_cyc1, n_ld1;
    int n_em2, n_done2, done_cyc2, n_te2;
    logic [15:0] ld_seq2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic clr();
        cyc = 0;
        n_rh0 = 0; n_sn0 = 0; n_em0 = 0; n_done0 = 0; done_cyc0 = -1; ld1_cyc0 = -1; n_te0 = 0;
        ls_seq0 = '0; ld_seq0 = '0;
        n_em1 = 0; n_done1 = 0; done_cyc1 = -1; te_cyc1 = -1; n_ld1 = 0;
        n_em2 = 0; n_done2 = 0; done_cyc2 = -1; n_te2 = 0; ld_seq2 = '0;
    endtask

    // Log the settled cycle, advance one clock, then drive the neuron models for the new cycle.
    task automatic tick();
        if (r0_rh) n_rh0++;
        if (r0_sn) begin n_sn0++; ls_seq0 = (ls_seq0 << 2) | 16'(r0_ls); end
        if (r0_ld != 0) ld_seq0 = (ld_seq0 << 2) | 16'(r0_ld);
        if (r0_ld[1] && ld1_cyc0 < 0) ld1_cyc0 = cyc;
        if (r0_em) n_em0++;
        if (r0_done) begin n_done0++; done_cyc0 = cyc; end
        if (r0_te) n_te0++;
        if (r1_em) n_em1++;
        if (r1_done) begin n_done1++; done_cyc1 = cyc; end
        if (r1_te && te_cyc1 < 0) te_cyc1 = cyc;
        if (r1_ld != 0) n_ld1++;
        if (r2_ld != 0) ld_seq2 = (ld_seq2 << 4) | 16'(r2_ld);
        if (r2_em) n_em2++;
        if (r2_done) begin n_done2++; done_cyc2 = cyc; end
        if (r2_te) n_te2++;
        @(posedge clk);
        #1;
        cyc++;
        age0 = r0_sn ? 0 : age0 + 1;
        for (int i = 0; i < 10; i++)
            rdy0[i] = age0 >= dly0 + ((i == 7 && late0 && r0_ls == 2'd1) ? 20 : 0);
        age1 = r1_sn ? 0 : age1 + 1;
        rdy1 = stuck1 ? 10'h3FE : (age1 >= dly1 ? 10'h3FF : 10'h000);
        age2 = r2_sn ? 0 : age2 + 1;
        rdy2 = age2 >= dly2 ? 4'hF : 4'h0;
        #1;
    endtask

    initial begin
        clr();
        repeat (3) tick();
        check("rst_ready_circuit", r0_rc, 1);
        check("rst_busy", r0_busy, 0);
        check("rst_layer_sel", r0_ls, 3);
        check("rst_strobes", {r0_rh, r0_sn, r0_ld, r0_em, r0_done, r0_te}, 0);
        check("rst_layer_sel5", r2_ls, 5);
        rst = 0;
        tick();

        // nominal: ready 4 cycles after each kick
        dly0 = 4; clr();
        s0_start = 1; tick(); s0_start = 0;
        repeat (19) tick();
        check("nom_rst_hidden", n_rh0, 1);
        check("nom_kicks", n_sn0, 3);
        check("nom_ld_seq", ld_seq0, 16'h0006);
        check("nom_lsel_at_kick", ls_seq0, 16'h0006);
        check("nom_en_max", n_em0, 1);
        check("nom_done_count", n_done0, 1);
        check("nom_done_cycle", done_cyc0, 18);
        check("nom_idle_rc", r0_rc, 1);
        check("nom_idle_lsel", r0_ls, 3);

        // bit 7 late by 20 cycles on layer 1
        late0 = 1; clr();
        s0_start = 1; tick(); s0_start = 0;
        repeat (39) tick();
        late0 = 0;
        check("late_ld1_cycle", ld1_cyc0, 31);
        check("late_ld_seq", ld_seq0, 16'h0006);
        check("late_done_cycle", done_cyc0, 38);
        check("late_no_timeout", n_te0, 0);

        // start held high: one inference per IDLE visit
        dly0 = 1; clr();
        s0_start = 1;
        repeat (20) tick();
        s0_start = 0;
        check("held_done_count", n_done0, 2);
        check("held_kicks", n_sn0, 6);
        check("held_rst_hidden", n_rh0, 2);
        check("held_idle_rc", r0_rc, 1);
        tick();
        check("held_no_third", r0_busy, 0);

        // reset in the middle of WAIT
        dly0 = 100; clr();
        s0_start = 1; tick(); s0_start = 0;
        repeat (3) tick();
        check("midrst_busy_before", r0_busy, 1);
        rst = 1; tick();
        check("midrst_rc", r0_rc, 1);
        check("midrst_busy", r0_busy, 0);
        check("midrst_lsel", r0_ls, 3);
        check("midrst_sn", r0_sn, 0);
        rst = 0; tick();

        // watchdog: ready stuck at 3FE on layer 0
        stuck1 = 1; clr();
        s1_start = 1; tick(); s1_start = 0;
        repeat (10) tick();
        check("to_err_cycle", te_cyc1, 10);
        check("to_no_done", n_done1, 0);
        check("to_no_ld", n_ld1, 0);
        check("to_sticky", r1_te, 1);
        check("to_idle", r1_rc, 1);
        stuck1 = 0; dly1 = 1; clr();
        s1_start = 1; tick(); s1_start = 0;
        check("to_cleared", r1_te, 0);
        repeat (9) tick();
        check("to_rerun_done", done_cyc1, 9);

        // ready on exactly the TIMEOUT-th WAIT cycle wins
        dly1 = 8; clr();
        s1_start = 1; tick(); s1_start = 0;
        repeat (30) tick();
        check("edge_done_cycle", done_cyc1, 30);
        check("edge_en_max", n_em1, 1);
        check("edge_no_err", r1_te, 0);

        // abort in final WAIT with ready full
        dly1 = 1; clr();
        s1_start = 1; tick(); s1_start = 0;
        repeat (7) tick();
        check("abort_in_l2", r1_ls, 2);
        s1_abort = 1; #1;
        check("abort_em_low", r1_em, 0);
        tick();
        s1_abort = 0;
        check("abort_rc", r1_rc, 1);
        check("abort_busy", r1_busy, 0);
        tick();
        check("abort_no_em", n_em1, 0);
        check("abort_no_done", n_done1, 0);

        // five layers, watchdog disabled, 1000-cycle waits
        dly2 = 1000; clr();
        s2_start = 1; tick(); s2_start = 0;
        repeat (5011) tick();
        check("l5_done_cycle", done_cyc2, 5010);
        check("l5_done_count", n_done2, 1);
        check("l5_ld_seq", ld_seq2, 16'h1248);
        check("l5_en_max", n_em2, 1);
        check("l5_no_err", n_te2, 0);
        check("l5_idle_lsel", r2_ls, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Parametrised controller that sequences an N-layer fully parallel neuron array through inference: it kicks all neurons, waits for the full ready vector, loads the inter-layer register bank, advances the layer, and finally enables the argmax stage. It sits between the top-level inference handshake and the neuron array / weight-bias mux, and adds a per-layer watchdog, abort, and explicit done/error reporting.

## Interface
- N_NEURONS, 10, neurons per layer (width of ready vector)
- N_LAYERS, 3, layer count, must be >= 2
- TIMEOUT, 1023, max WAIT cycles per layer before error; 0 disables the watchdog
- LSEL_W, $clog2(N_LAYERS+1), width of layer_sel (derived, not overridden)
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- start_circuit  in  1  request inference; honoured only in IDLE
- abort  in  1  cancel a running inference
- neuron_ready  in  N_NEURONS  per-neuron done flags
- ready_circuit  out  1  high in IDLE only
- busy  out  1  high in every non-IDLE state
- rst_hidden_regs  out  1  clears hidden registers at layer 0 kick
- start_neurons  out  1  one-cycle kick to all neurons
- layer_sel  out  LSEL_W  weight/bias/data select; N_LAYERS when idle
- ld_layer  out  N_LAYERS-1  one-hot load strobe for inter-layer register bank k
- en_max  out  1  one-cycle argmax enable after final layer
- done  out  1  one-cycle completion pulse
- timeout_err  out  1  sticky watchdog flag, cleared by rst or next accepted start

## Operation
- States: IDLE, KICK, WAIT, GAP, DONE, ERR. Layer counter lyr (0..N_LAYERS-1); wait counter wcnt.
- IDLE: ready_circuit=1, layer_sel=N_LAYERS. start_circuit -> KICK, lyr=0, timeout_err cleared.
- KICK: start_neurons=1; rst_hidden_regs=1 iff lyr==0; wcnt=0; -> WAIT.
- WAIT: layer_sel=lyr; wcnt increments each cycle. All-ready (&neuron_ready) same cycle: lyr<N_LAYERS-1 -> ld_layer[lyr]=1 (combinational with the ready condition), -> GAP; lyr==N_LAYERS-1 -> en_max=1, -> DONE. Otherwise, TIMEOUT!=0 and wcnt reaches TIMEOUT -> ERR.
- GAP: all strobes low, layer_sel=lyr; lyr++ -> KICK.
- DONE: done=1 -> IDLE. ERR: timeout_err set (sticky) -> IDLE; done not asserted.
- Neuron contract: ready deasserted by the first WAIT cycle after the kick; ready is sampled from that cycle.
- Priority: rst > abort > all-ready > timeout. abort in any non-IDLE state -> IDLE next cycle, no done, no strobe that cycle, timeout_err unchanged. abort in IDLE ignored.
- start_circuit while busy ignored; no queuing.

## Timing
- Reset (sync): state=IDLE, lyr=0, wcnt=0; outputs: ready_circuit=1, layer_sel=N_LAYERS, all others 0.
- All strobes (start_neurons, rst_hidden_regs, ld_layer, en_max, done) are single-cycle.
- Start sampled at edge E0 (cycle 0). With ready full on first WAIT cycle, each non-final layer costs 3 cycles (KICK, WAIT, GAP), final layer 2; done high in cycle 3*N_LAYERS (N_LAYERS=3 -> cycle 9). Each extra WAIT cycle adds 1.
- Timeout: ERR entered after TIMEOUT consecutive WAIT cycles without full ready; ready arriving on cycle TIMEOUT wins.
- wcnt width $clog2(TIMEOUT+1) (min 1); saturates, no wrap.

## Structure
- Package nn_seq_pkg: state enum, IDLE_LSEL helper (N_LAYERS), state encoding constants.
- Sub-module nn_wait_timer: clear/enable counter with TIMEOUT compare and disable-when-0; FSM and layer counter stay in nn_layer_sequencer.

## Test plan
- Nominal N_LAYERS=3, N_NEURONS=10, ready full 4 cycles after each kick -> rst_hidden_regs only at first kick, ld_layer=01 then 10, en_max once, done in cycle 18, layer_sel 0,1,2 then 3.
- One neuron (bit 7) late by 20 cycles on layer 1 -> no ld_layer[1] until bit 7 rises; same-cycle strobe; no timeout.
- TIMEOUT=8, ready stuck at 10'h3FE on layer 0 -> ERR after 8 WAIT cycles, timeout_err=1, done=0, IDLE; next start clears timeout_err.
- abort in WAIT of layer 2 with ready full same cycle -> no en_max, no done, IDLE next cycle, ready_circuit=1.
- start_circuit held high through a run -> exactly one inference per IDLE visit, start ignored while busy; rst mid-WAIT -> reset values next cycle.
- N_LAYERS=5, N_NEURONS=4, TIMEOUT=0, ready after 1000 cycles -> no error, ld_layer walks 0001..1000, done once.
